trap_controller: RTL and testbench

- Sits directly upstream of the CSR file and commits traps at writeback, so exceptions are carried as pending bits and take effect only at writeback.
- Arbitrates writeback exceptions, the external interrupt and MRET, then produces the CSR-file strobes: controlReset, mcause, mtval, trap PC and mretSignal.
- Drives a pipeline flush and a fetch redirect to mtvec or mepc, held through a ready handshake.

---
 rtl/trap_controller_pkg.sv | 22 ++
 rtl/trap_controller_trap_arbiter.sv | 41 ++++
 rtl/trap_controller.sv | 142 ++++++++++++++
 tb/tb_trap_controller.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_controller_pkg.sv
// Shared types and cause codes for the trap controller and its arbiter.
package trap_controller_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } trapState_;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EXC  = 2'd1,
        IRQ  = 2'd2,
        MRET = 2'd3
    } trapKind_;

    localparam logic [3:0] CAUSE_MEXT_IRQ         = 4'hB;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'h2;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'hB;
    localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'h0;

endpackage

// File: rtl/trap_controller_trap_arbiter.sv
// Combinational writeback arbiter: exception > interrupt > MRET.
// The interrupt path exists only when TRAP_IRQ_EN is defined.
module trap_arbiter
    import trap_controller_pkg::*;
(
    input  logic     enable,
    input  logic     wbValid,
    input  logic     wbExceptionPending,
    input  logic     wbMret,
    input  logic     interrupt,
    input  logic     mstatusMIE,
    output trapKind_ kind,
    output logic     wbKill
);

`ifdef TRAP_IRQ_EN
    localparam logic IRQ_PATH = 1'b1;
`else
    localparam logic IRQ_PATH = 1'b0;
`endif

    logic irqReq;
    assign irqReq = IRQ_PATH & interrupt & mstatusMIE;

    always_comb begin
        kind   = NONE;
        wbKill = 1'b0;
        if (enable && wbValid) begin
            if (wbExceptionPending) begin
                kind = EXC;
            end else if (irqReq) begin
                kind = IRQ;
            end else if (wbMret) begin
                kind = MRET;
            end
        end
        // MRET retires normally; only traps squash the writeback instruction.
        wbKill = (kind == EXC) || (kind == IRQ);
    end

endmodule

// File: rtl/trap_controller.sv
// Trap commit FSM: CSR strobes, pipeline flush and fetch redirect handshake.
// Optional interrupt arbitration is enabled by defining TRAP_IRQ_EN.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned XLEN         = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wbValid,
    input  logic [XLEN-1:0] wbPC,
    input  logic            wbExceptionPending,
    input  logic [3:0]      wbExceptionCause,
    input  logic [XLEN-1:0] wbExceptionValue,
    input  logic            wbMret,
    input  logic            interrupt,
    input  logic            mstatusMIE,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            fetchReady,
    output logic            wbKill,
    output logic            controlReset,
    output logic [3:0]      mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] trapPC,
    output logic            mretSignal,
    output logic            pipelineFlush,
    output logic            redirectValid,
    output logic [XLEN-1:0] redirectPC
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    trapState_       state, stateNext;
    trapKind_        kind;
    logic [3:0]      cnt, cntNext;
    logic            targetMret, targetMretNext;
    logic            controlResetNext, mretSignalNext;
    logic            pipelineFlushNext, redirectValidNext;
    logic [3:0]      mcauseNext;
    logic [XLEN-1:0] mtvalNext, trapPCNext, redirectPCNext;

    trap_arbiter u_arbiter (
        .enable             (state == IDLE),
        .wbValid            (wbValid),
        .wbExceptionPending (wbExceptionPending),
        .wbMret             (wbMret),
        .interrupt          (interrupt),
        .mstatusMIE         (mstatusMIE),
        .kind               (kind),
        .wbKill             (wbKill)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            targetMret    <= 1'b0;
            controlReset  <= 1'b0;
            mretSignal    <= 1'b0;
            pipelineFlush <= 1'b0;
            redirectValid <= 1'b0;
            mcause        <= '0;
            mtval         <= '0;
            trapPC        <= '0;
            redirectPC    <= '0;
        end else begin
            state         <= stateNext;
            cnt           <= cntNext;
            targetMret    <= targetMretNext;
            controlReset  <= controlResetNext;
            mretSignal    <= mretSignalNext;
            pipelineFlush <= pipelineFlushNext;
            redirectValid <= redirectValidNext;
            mcause        <= mcauseNext;
            mtval         <= mtvalNext;
            trapPC        <= trapPCNext;
            redirectPC    <= redirectPCNext;
        end
    end

    always_comb begin
        stateNext         = state;
        cntNext           = cnt;
        targetMretNext    = targetMret;
        controlResetNext  = 1'b0;
        mretSignalNext    = 1'b0;
        pipelineFlushNext = pipelineFlush;
        redirectValidNext = redirectValid;
        mcauseNext        = mcause;
        mtvalNext         = mtval;
        trapPCNext        = trapPC;
        redirectPCNext    = redirectPC;

        case (state)
            IDLE: begin
                if (kind != NONE) begin
                    stateNext         = FLUSH;
                    cntNext           = FLUSH_LOAD;
                    pipelineFlushNext = 1'b1;
                    targetMretNext    = (kind == MRET);
                    if (kind == MRET) begin
                        mretSignalNext = 1'b1;
                    end else begin
                        controlResetNext = 1'b1;
                        trapPCNext       = wbPC;
                        if (kind == IRQ) begin
                            mcauseNext = CAUSE_MEXT_IRQ;
                            mtvalNext  = '0;
                        end else begin
                            mcauseNext = wbExceptionCause;
                            mtvalNext  = wbExceptionValue;
                        end
                    end
                end
            end
            FLUSH: begin
                // The vector is sampled only at the end of the flush so the
                // CSR write triggered by the strobe has already landed.
                if (cnt == 4'd0) begin
                    stateNext         = REDIRECT;
                    pipelineFlushNext = 1'b0;
                    redirectValidNext = 1'b1;
                    redirectPCNext    = targetMret ? mepc : mtvec;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            REDIRECT: begin
                if (fetchReady) begin
                    stateNext         = IDLE;
                    redirectValidNext = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller with a timeline-based reference model.
// Expectations for the interrupt path follow TRAP_IRQ_EN.
module tb_trap_controller;

    localparam int F = 2;

`ifdef TRAP_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wbValid = 1'b0;
    logic [31:0] wbPC = '0;
    logic        wbExceptionPending = 1'b0;
    logic [3:0]  wbExceptionCause = '0;
    logic [31:0] wbExceptionValue = '0;
    logic        wbMret = 1'b0;
    logic        interrupt = 1'b0;
    logic        mstatusMIE = 1'b0;
    logic [31:0] mtvec = 32'h80;
    logic [31:0] mepc = 32'h104;
    logic        fetchReady = 1'b0;
    logic        wbKill, controlReset, mretSignal, pipelineFlush, redirectValid;
    logic [3:0]  mcause;
    logic [31:0] mtval, trapPC, redirectPC;

    always #5 clock = ~clock;

    trap_controller #(.FLUSH_CYCLES(F), .XLEN(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .wbValid            (wbValid),
        .wbPC               (wbPC),
        .wbExceptionPending (wbExceptionPending),
        .wbExceptionCause   (wbExceptionCause),
        .wbExceptionValue   (wbExceptionValue),
        .wbMret             (wbMret),
        .interrupt          (interrupt),
        .mstatusMIE         (mstatusMIE),
        .mtvec              (mtvec),
        .mepc               (mepc),
        .fetchReady         (fetchReady),
        .wbKill             (wbKill),
        .controlReset       (controlReset),
        .mcause             (mcause),
        .mtval              (mtval),
        .trapPC             (trapPC),
        .mretSignal         (mretSignal),
        .pipelineFlush      (pipelineFlush),
        .redirectValid      (redirectValid),
        .redirectPC         (redirectPC)
    );

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: an accepted event at edge evEdge gives a strobe in cycle evEdge,
    // flush in cycles evEdge..evEdge+F-1, redirect from cycle evEdge+F on.
    int          edgeIdx = 0;
    int          evEdge = 0;
    bit          mActive = 1'b0;
    bit          mIsMret = 1'b0;
    logic [3:0]  mCause = '0;
    logic [31:0] mTval = '0, mTrapPC = '0, mRedir = '0;

    function automatic int modelKind();
        if (!wbValid) return 0;
        if (wbExceptionPending) return 1;
        if (IRQ_ON && interrupt && mstatusMIE) return 2;
        if (wbMret) return 3;
        return 0;
    endfunction

    always @(posedge clock or negedge reset) begin
        int k;
        if (!reset) begin
            mActive = 1'b0;
            mCause  = '0;
            mTval   = '0;
            mTrapPC = '0;
            mRedir  = '0;
        end else begin
            edgeIdx++;
            if (mActive) begin
                if (edgeIdx == evEdge + F) begin
                    mRedir = mIsMret ? mepc : mtvec;
                end else if (edgeIdx > evEdge + F && fetchReady) begin
                    mActive = 1'b0;
                end
            end else begin
                k = modelKind();
                if (k != 0) begin
                    mActive = 1'b1;
                    evEdge  = edgeIdx;
                    mIsMret = (k == 3);
                    if (k == 1) begin
                        mCause  = wbExceptionCause;
                        mTval   = wbExceptionValue;
                        mTrapPC = wbPC;
                    end else if (k == 2) begin
                        mCause  = 4'hB;
                        mTval   = '0;
                        mTrapPC = wbPC;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        int k;
        if (cmpEn) begin
            k = modelKind();
            chk1("cmp_wbKill", wbKill, !mActive && (k == 1 || k == 2));
            chk1("cmp_controlReset", controlReset, mActive && edgeIdx == evEdge && !mIsMret);
            chk1("cmp_mretSignal", mretSignal, mActive && edgeIdx == evEdge && mIsMret);
            chk1("cmp_pipelineFlush", pipelineFlush, mActive && edgeIdx < evEdge + F);
            chk1("cmp_redirectValid", redirectValid, mActive && edgeIdx >= evEdge + F);
            chk32("cmp_mcause", 32'(mcause), 32'(mCause));
            chk32("cmp_mtval", mtval, mTval);
            chk32("cmp_trapPC", trapPC, mTrapPC);
            chk32("cmp_redirectPC", redirectPC, mRedir);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clock);
    endtask

    task automatic clearWb();
        wbValid = 1'b0;
        wbExceptionPending = 1'b0;
        wbMret = 1'b0;
        interrupt = 1'b0;
        mstatusMIE = 1'b0;
    endtask

    task automatic driveExc(input logic [31:0] pc, input logic [3:0] cause, input logic [31:0] val);
        wbValid = 1'b1;
        wbExceptionPending = 1'b1;
        wbExceptionCause = cause;
        wbPC = pc;
        wbExceptionValue = val;
    endtask

    // Called during a REDIRECT cycle; completes the handshake and checks the drop.
    task automatic handshake(input string name);
        step();
        fetchReady = 1'b1;
        step();
        fetchReady = 1'b0;
        atNeg();
        chk1(name, redirectValid, 1'b0);
    endtask

    // Finishes any outstanding redirect without directed checks.
    task automatic drain();
        fetchReady = 1'b1;
        repeat (8) step();
        fetchReady = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        reset = 1'b1;
        cmpEn = 1'b1;

        atNeg();
        chk1("rst_controlReset", controlReset, 1'b0);
        chk1("rst_pipelineFlush", pipelineFlush, 1'b0);
        chk1("rst_redirectValid", redirectValid, 1'b0);
        chk32("rst_mcause", 32'(mcause), 32'h0);
        chk32("rst_redirectPC", redirectPC, 32'h0);

        // Illegal instruction
        step();
        driveExc(32'h100, 4'h2, 32'hDEADBEEF);
        atNeg();
        chk1("ill_wbKill", wbKill, 1'b1);
        step();
        clearWb();
        atNeg();
        chk1("ill_controlReset", controlReset, 1'b1);
        chk32("ill_mcause", 32'(mcause), 32'h2);
        chk32("ill_mtval", mtval, 32'hDEADBEEF);
        chk32("ill_trapPC", trapPC, 32'h100);
        chk1("ill_flush1", pipelineFlush, 1'b1);
        step();
        atNeg();
        chk1("ill_controlReset2", controlReset, 1'b0);
        chk1("ill_flush2", pipelineFlush, 1'b1);
        chk1("ill_rv_early", redirectValid, 1'b0);
        step();
        atNeg();
        chk1("ill_flush3", pipelineFlush, 1'b0);
        chk1("ill_rv", redirectValid, 1'b1);
        chk32("ill_redirectPC", redirectPC, 32'h80);
        handshake("ill_rv_drop");

        // MRET
        step();
        wbValid = 1'b1;
        wbMret = 1'b1;
        wbPC = 32'h84;
        atNeg();
        chk1("mret_wbKill", wbKill, 1'b0);
        step();
        clearWb();
        atNeg();
        chk1("mret_signal", mretSignal, 1'b1);
        chk1("mret_controlReset", controlReset, 1'b0);
        step();
        atNeg();
        chk1("mret_signal_once", mretSignal, 1'b0);
        step();
        atNeg();
        chk1("mret_rv", redirectValid, 1'b1);
        chk32("mret_redirectPC", redirectPC, 32'h104);
        handshake("mret_rv_drop");

        // Priority: everything asserted
        step();
        driveExc(32'h200, 4'h0, 32'h55);
        interrupt = 1'b1;
        mstatusMIE = 1'b1;
        wbMret = 1'b1;
        atNeg();
        chk1("pri_wbKill", wbKill, 1'b1);
        step();
        clearWb();
        atNeg();
        chk1("pri_controlReset", controlReset, 1'b1);
        chk1("pri_mretSignal", mretSignal, 1'b0);
        chk32("pri_mcause", 32'(mcause), 32'h0);
        chk32("pri_mtval", mtval, 32'h55);
        step();
        step();
        handshake("pri_rv_drop");

        // Priority without the exception
        step();
        wbValid = 1'b1;
        wbPC = 32'h300;
        interrupt = 1'b1;
        mstatusMIE = 1'b1;
        wbMret = 1'b1;
        atNeg();
        chk1("irq_wbKill", wbKill, IRQ_ON);
        step();
        clearWb();
        atNeg();
        chk1("irq_controlReset", controlReset, IRQ_ON);
        chk1("irq_mretSignal", mretSignal, !IRQ_ON);
        chk32("irq_mcause", 32'(mcause), IRQ_ON ? 32'hB : 32'h0);
        chk32("irq_mtval", mtval, IRQ_ON ? 32'h0 : 32'h55);
        chk32("irq_trapPC", trapPC, IRQ_ON ? 32'h300 : 32'h200);
        step();
        step();
        handshake("irq_rv_drop");

        // Redirect held off while writeback noise arrives
        step();
        driveExc(32'h400, 4'h2, 32'h11);
        step();
        clearWb();
        step();
        step();
        atNeg();
        chk1("hold_rv_start", redirectValid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            driveExc(32'h500, 4'h2, 32'h99);
            atNeg();
            chk1("hold_rv", redirectValid, 1'b1);
            chk32("hold_redirectPC", redirectPC, 32'h80);
            chk1("hold_controlReset", controlReset, 1'b0);
            chk1("hold_wbKill", wbKill, 1'b0);
        end
        step();
        clearWb();
        fetchReady = 1'b1;
        atNeg();
        chk1("hold_rv_last", redirectValid, 1'b1);
        step();
        fetchReady = 1'b0;
        driveExc(32'h600, 4'h2, 32'h66);
        atNeg();
        chk1("post_rv", redirectValid, 1'b0);
        chk1("post_wbKill", wbKill, 1'b1);
        step();
        clearWb();
        atNeg();
        chk1("post_controlReset", controlReset, 1'b1);
        chk32("post_trapPC", trapPC, 32'h600);
        drain();

        // Reset in the middle of the flush
        driveExc(32'h700, 4'h2, 32'h22);
        step();
        clearWb();
        #2;
        reset = 1'b0;
        #1;
        chk1("rstm_flush", pipelineFlush, 1'b0);
        chk1("rstm_controlReset", controlReset, 1'b0);
        chk32("rstm_mcause", 32'(mcause), 32'h0);
        chk32("rstm_trapPC", trapPC, 32'h0);
        chk32("rstm_mtval", mtval, 32'h0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            atNeg();
            chk1("rstm_rv", redirectValid, 1'b0);
            chk1("rstm_cr", controlReset, 1'b0);
        end
        step();
        driveExc(32'h800, 4'h2, 32'h33);
        atNeg();
        chk1("rstm_idle_kill", wbKill, 1'b1);
        step();
        clearWb();
        atNeg();
        chk1("rstm_idle_cr", controlReset, 1'b1);
        drain();

        // Interrupt alone, then an exception
        wbValid = 1'b1;
        wbPC = 32'h900;
        interrupt = 1'b1;
        mstatusMIE = 1'b1;
        atNeg();
        chk1("irqonly_wbKill", wbKill, IRQ_ON);
        step();
        clearWb();
        atNeg();
        chk1("irqonly_controlReset", controlReset, IRQ_ON);
        step();
        drain();
        driveExc(32'hA00, 4'h2, 32'h44);
        interrupt = 1'b1;
        mstatusMIE = 1'b1;
        atNeg();
        chk1("exc_after_wbKill", wbKill, 1'b1);
        step();
        clearWb();
        atNeg();
        chk1("exc_after_cr", controlReset, 1'b1);
        chk32("exc_after_mcause", 32'(mcause), 32'h2);
        drain();

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
